// File: rtl/rotary_step_counter_if.sv
// Signal bundle for rotary_step_counter: raw shaft contacts and controls in,
// decoded detent events and position out.
interface rotary_step_counter_if #(
  parameter int unsigned CNT_W = 8
);
  logic             ROT_A;
  logic             ROT_B;
  logic             enable;
  logic             sat_mode;
  logic             clear;
  logic             rotation_event;
  logic             rotation_direction;
  logic             step_pulse;
  logic [CNT_W-1:0] count;
  logic             limit_hit;

  modport master (
    output ROT_A, ROT_B, enable, sat_mode, clear,
    input  rotation_event, rotation_direction, step_pulse, count, limit_hit
  );

  modport slave (
    input  ROT_A, ROT_B, enable, sat_mode, clear,
    output rotation_event, rotation_direction, step_pulse, count, limit_hit
  );
endinterface

// File: rtl/rotary_step_counter.sv
// Quadrature detent decoder with up/down position counter (wrap or saturate).
// Define ROT_DEBOUNCE_EN to build the FILT_LEN-sample debounce filter.
module rotary_step_counter #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned FILT_LEN = 4
) (
  input logic             clk,
  input logic             rst_n,
  rotary_step_counter_if.slave rot
);

  if (CNT_W < 2 || CNT_W > 32 || FILT_LEN < 2 || FILT_LEN > 255) begin : g_param_check
    $error("rotary_step_counter: CNT_W or FILT_LEN out of range");
  end

  typedef enum logic {StLow, StHigh} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  // Pair ordering throughout is {A, B}.
  logic [1:0] meta_q, sync_q, filt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= {rot.ROT_A, rot.ROT_B};
      sync_q <= meta_q;
    end
  end

`ifdef ROT_DEBOUNCE_EN
  localparam int unsigned RunW = 8;

  logic [1:0]      filt_q;
  logic [RunW-1:0] run_q [2];

  // A run counts consecutive cycles of disagreement; any agreement restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_q <= 2'b00;
      for (int i = 0; i < 2; i++) run_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] != filt_q[i]) begin
          if (run_q[i] == RunW'(FILT_LEN - 1)) begin
            filt_q[i] <= sync_q[i];
            run_q[i]  <= '0;
          end else begin
            run_q[i]  <= run_q[i] + RunW'(1);
          end
        end else begin
          run_q[i] <= '0;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_q;
`endif

  state_e           state_q;
  logic             dir_q, step_q, limit_q;
  logic [CNT_W-1:0] count_q;
  logic             step_edge;

  assign step_edge = (state_q == StLow) && (filt == 2'b11);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StLow;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      limit_q <= 1'b0;
      count_q <= '0;
    end else begin
      step_q  <= 1'b0;
      limit_q <= 1'b0;

      unique case (state_q)
        StLow:  if (filt == 2'b11) begin
                  state_q <= StHigh;
                  step_q  <= 1'b1;
                end
        StHigh: if (filt == 2'b00) state_q <= StLow;
      endcase

      if (filt == 2'b01)      dir_q <= 1'b1;
      else if (filt == 2'b10) dir_q <= 1'b0;

      // Clear wins over a coincident step and suppresses limit_hit.
      if (rot.clear) begin
        count_q <= '0;
      end else if (step_edge && rot.enable) begin
        if (!dir_q) begin
          if (count_q == CntMax) begin
            limit_q <= 1'b1;
            if (!rot.sat_mode) count_q <= '0;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end else begin
          if (count_q == '0) begin
            limit_q <= 1'b1;
            if (!rot.sat_mode) count_q <= CntMax;
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
        end
      end
    end
  end

  assign rot.rotation_event     = (state_q == StHigh);
  assign rot.rotation_direction = dir_q;
  assign rot.step_pulse         = step_q;
  assign rot.count              = count_q;
  assign rot.limit_hit          = limit_q;

endmodule

// File: tb/tb_rotary_step_counter.sv
// Scoreboard bench for rotary_step_counter: each detent pushes its expected
// step result; a negedge monitor pops and compares when step_pulse fires.
module tb_rotary_step_counter;

  localparam int unsigned CntW    = 8;
  localparam int unsigned FiltLen = 4;
`ifdef ROT_DEBOUNCE_EN
  localparam int Lat         = 2 + FiltLen + 1;
  localparam bit FilterBuilt = 1'b1;
`else
  localparam int Lat         = 3;
  localparam bit FilterBuilt = 1'b0;
`endif

  typedef struct {
    int             cyc;
    logic [CntW-1:0] cnt;
    logic           lim;
    logic           dir;
  } sb_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  sb_t  sb [$];
  sb_t  got;

  logic [CntW-1:0] mdl_count;
  logic            mdl_dir;

  rotary_step_counter_if #(.CNT_W(CntW)) rot_if ();

  rotary_step_counter #(
    .CNT_W   (CntW),
    .FILT_LEN(FiltLen)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rot  (rot_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rot_if.step_pulse) begin
      check_eq("step_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        got = sb.pop_front();
        check_eq("step_cycle", cyc, got.cyc);
        check_eq("step_count", 32'(rot_if.count), 32'(got.cnt));
        check_eq("step_limit_hit", 32'(rot_if.limit_hit), 32'(got.lim));
        check_eq("step_direction", 32'(rot_if.rotation_direction), 32'(got.dir));
      end
    end
    if (rst_n && rot_if.limit_hit && !rot_if.step_pulse)
      check_eq("limit_hit_without_step", 32'(rot_if.step_pulse), 1);
  end

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pair(input logic a, input logic b, input int n);
    rot_if.ROT_A = a;
    rot_if.ROT_B = b;
    hold(n);
  endtask

  task automatic pulse_clear();
    rot_if.clear = 1'b1;
    hold(1);
    rot_if.clear = 1'b0;
    mdl_count = '0;
    check_eq("count_after_clear", 32'(rot_if.count), 0);
  endtask

  // One full detent, 10 cycles per phase; optional clear on the step edge.
  task automatic detent(input bit cw, input bit en, input bit sat, input bit clr);
    sb_t e;
    rot_if.enable   = en;
    rot_if.sat_mode = sat;
    set_pair(1'b0, 1'b0, 10);
    if (cw) set_pair(1'b1, 1'b0, 10);
    else    set_pair(1'b0, 1'b1, 10);
    mdl_dir = cw ? 1'b0 : 1'b1;
    e.lim   = 1'b0;
    if (clr) begin
      mdl_count = '0;
    end else if (en) begin
      if (!mdl_dir) begin
        if (mdl_count == '1) begin
          e.lim = 1'b1;
          if (!sat) mdl_count = '0;
        end else mdl_count = mdl_count + 1'b1;
      end else begin
        if (mdl_count == '0) begin
          e.lim = 1'b1;
          if (!sat) mdl_count = '1;
        end else mdl_count = mdl_count - 1'b1;
      end
    end
    e.cnt = mdl_count;
    e.dir = mdl_dir;
    rot_if.ROT_A = 1'b1;
    rot_if.ROT_B = 1'b1;
    e.cyc = cyc + Lat;
    sb.push_back(e);
    hold(Lat - 1);
    rot_if.clear = clr;
    hold(1);
    rot_if.clear = 1'b0;
    hold(10 - Lat);
    check_eq("event_high_after_11", 32'(rot_if.rotation_event), 1);
    set_pair(1'b0, 1'b0, 10);
    check_eq("event_low_after_00", 32'(rot_if.rotation_event), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_event"}, 32'(rot_if.rotation_event), 0);
    check_eq({tag, "_dir"}, 32'(rot_if.rotation_direction), 0);
    check_eq({tag, "_step"}, 32'(rot_if.step_pulse), 0);
    check_eq({tag, "_count"}, 32'(rot_if.count), 0);
    check_eq({tag, "_limit"}, 32'(rot_if.limit_hit), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    mdl_count = '0;
    mdl_dir = 1'b0;
    rst_n = 1'b0;
    rot_if.ROT_A = 1'b0;
    rot_if.ROT_B = 1'b0;
    rot_if.enable = 1'b1;
    rot_if.sat_mode = 1'b0;
    rot_if.clear = 1'b0;
    hold(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    hold(2);

    // CCW from 0 wraps to max; then saturating CCW holds at 0.
    detent(1'b0, 1'b1, 1'b0, 1'b0);
    pulse_clear();
    detent(1'b0, 1'b1, 1'b1, 1'b0);

    // CW up to 5, the reference detent to 6, then on to 9.
    for (int i = 0; i < 5; i++) detent(1'b1, 1'b1, 1'b0, 1'b0);
    detent(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("count_six", 32'(rot_if.count), 6);
    for (int i = 0; i < 3; i++) detent(1'b1, 1'b1, 1'b0, 1'b0);

    // Clear on the step edge, then a step with enable low.
    detent(1'b1, 1'b1, 1'b0, 1'b1);
    detent(1'b1, 1'b0, 1'b0, 1'b0);

    // Leave direction at 1, then glitch A high for 3 cycles.
    detent(1'b0, 1'b1, 1'b0, 1'b0);
    set_pair(1'b1, 1'b0, 3);
    set_pair(1'b0, 1'b0, 12);
    check_eq("glitch_direction", 32'(rot_if.rotation_direction), FilterBuilt ? 1 : 0);
    check_eq("glitch_event", 32'(rot_if.rotation_event), 0);

    // Reach 42, then reset in the middle of a filter run.
    pulse_clear();
    for (int i = 0; i < 42; i++) detent(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("count_42", 32'(rot_if.count), 42);
    rot_if.ROT_A = 1'b1;
    hold(3);
    rst_n = 1'b0;
    hold(1);
    rst_n = 1'b1;
    rot_if.ROT_A = 1'b0;
    mdl_count = '0;
    mdl_dir = 1'b0;
    check_all_zero("midrun_reset");
    hold(10);
    detent(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("count_after_reset_detent", 32'(rot_if.count), 1);

    hold(5);
    check_eq("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
